// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// The anode helper turns a digit index into its one-hot active-low enable pattern.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    S_BLANK,
    S_ON
  } scan_state_t;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_slot_timer.sv
// Slot counter and digit index for the scan controller.
// Strobes describe the current cycle; idx_next is the digit the following cycle belongs to.
module scan_slot_timer #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] idx,
  output logic [1:0] idx_next,
  output logic       slot_first,
  output logic       blank_end,
  output logic       slot_last,
  output logic       frame_last
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK == 0) ? 0 : BLANK - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // With no blanking there is no blank phase to end, so blank_end never fires.
  assign slot_first = (cnt == '0);
  assign blank_end  = (BLANK != 0) && (cnt == BLANK_LAST);
  assign slot_last  = (cnt == CNT_LAST);
  assign frame_last = slot_last && (idx == 2'd3);
  assign idx_next   = slot_last ? idx + 2'd1 : idx;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-buffered digit values loaded at
// frame boundaries via req/ack, blanking at the start of each slot, registered outputs.
module seven_seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [3:0] dp_in,
  input  logic [3:0] en_mask,
  input  logic       load_req,
  output logic       load_ack,
  output logic [3:0] nibble,
  output logic       dp,
  output logic [3:0] anode,
  output logic       frame_start
);

  localparam scan_state_t RESET_STATE = (BLANK == 0) ? S_ON : S_BLANK;

  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic        slot_first;
  logic        blank_end;
  logic        slot_last;
  logic        frame_last;

  scan_state_t state;
  scan_state_t state_next;

  logic [15:0] shadow;
  logic [15:0] shadow_next;
  logic [3:0]  shadow_dp;
  logic [3:0]  shadow_dp_next;
  logic        capture;

  logic [3:0]  anode_next;
  logic [3:0]  nibble_next;
  logic        dp_next;

  scan_slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .idx        (idx),
    .idx_next   (idx_next),
    .slot_first (slot_first),
    .blank_end  (blank_end),
    .slot_last  (slot_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // ON at counter 0 cannot happen with two or more blank cycles, so it is pulled back to BLANK.
  always_comb begin
    state_next = state;
    case (state)
      S_BLANK: begin
        if (blank_end) state_next = S_ON;
      end
      S_ON: begin
        if (slot_last) begin
          state_next = (BLANK == 0) ? S_ON : S_BLANK;
        end else if (slot_first && BLANK > 1) begin
          state_next = S_BLANK;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Newly captured values are forwarded so digit 0 shows them on the first cycle of the frame.
  always_comb begin
    capture        = frame_last && load_req;
    shadow_next    = capture ? {d, c, b, a} : shadow;
    shadow_dp_next = capture ? dp_in : shadow_dp;

    anode_next = ANODE_OFF;
    if (state_next == S_ON && en_mask[idx_next]) begin
      anode_next = anode_for(idx_next);
    end

    nibble_next = nibble;
    dp_next     = dp;
    if (slot_last) begin
      nibble_next = shadow_next[{idx_next, 2'b00} +: 4];
      dp_next     = shadow_dp_next[idx_next];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      shadow_dp   <= '0;
      anode       <= ANODE_OFF;
      nibble      <= '0;
      dp          <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      shadow      <= shadow_next;
      shadow_dp   <= shadow_dp_next;
      anode       <= anode_next;
      nibble      <= nibble_next;
      dp          <= dp_next;
      load_ack    <= capture;
      frame_start <= frame_last;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with PRESCALE=8, BLANK=2.
// Each slot is checked cycle by cycle against hand-computed anode/nibble/dp/strobe values.
module tb_seven_seg_scan_ctrl;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a = '0, b = '0, c = '0, d = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] en_mask = 4'b1111;
  logic       load_req = 1'b0;
  logic       load_ack;
  logic [3:0] nibble;
  logic       dp;
  logic [3:0] anode;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan_ctrl #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .dp_in       (dp_in),
    .en_mask     (en_mask),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .nibble      (nibble),
    .dp          (dp),
    .anode       (anode),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entered at counter 0 of a slot; returns at counter 0 of the next slot.
  task automatic check_slot(input string tag, input logic [3:0] exp_nib, input logic [3:0] exp_an,
                            input logic exp_dp, input logic exp_fs, input logic exp_ack);
    for (int k = 0; k < PRESCALE; k++) begin
      check_output($sformatf("%s anode k%0d", tag, k), anode, (k < BLANK) ? 4'b1111 : exp_an);
      check_output($sformatf("%s nibble k%0d", tag, k), nibble, exp_nib);
      check_output($sformatf("%s dp k%0d", tag, k), {3'b000, dp}, {3'b000, exp_dp});
      check_output($sformatf("%s frame_start k%0d", tag, k), {3'b000, frame_start},
                   {3'b000, (k == 0) ? exp_fs : 1'b0});
      check_output($sformatf("%s load_ack k%0d", tag, k), {3'b000, load_ack},
                   {3'b000, (k == 0) ? exp_ack : 1'b0});
      tick();
    end
  endtask

  initial begin
    $display("[TB] start");
    a = 4'd0; b = 4'd1; c = 4'd2; d = 4'd3;
    load_req = 1'b1;

    // Test 1: reset held five cycles, first frame shows the zeroed shadow
    #2 reset = 1'b0;
    #1;
    check_output("reset anode", anode, 4'b1111);
    check_output("reset nibble", nibble, 4'd0);
    check_output("reset load_ack", {3'b000, load_ack}, 4'd0);
    check_output("reset frame_start", {3'b000, frame_start}, 4'd0);
    repeat (5) begin
      tick();
      check_output("reset hold anode", anode, 4'b1111);
    end
    reset = 1'b1;
    check_slot("f1d0", 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    check_slot("f1d1", 4'd0, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f1d2", 4'd0, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f1d3", 4'd0, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Test 2: loaded 0,1,2,3 appear in frame 2
    check_slot("f2d0", 4'd0, 4'b1110, 1'b0, 1'b1, 1'b1);
    load_req = 1'b0;
    check_slot("f2d1", 4'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f2d2", 4'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f2d3", 4'd3, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Test 3: request raised mid-frame, old values hold until the boundary
    check_slot("f3d0", 4'd0, 4'b1110, 1'b0, 1'b1, 1'b0);
    a = 4'd9; b = 4'd8; c = 4'd7; d = 4'd6;
    load_req = 1'b1;
    check_slot("f3d1", 4'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f3d2", 4'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f3d3", 4'd3, 4'b0111, 1'b0, 1'b0, 1'b0);
    check_slot("f4d0", 4'd9, 4'b1110, 1'b0, 1'b1, 1'b1);
    load_req = 1'b0;
    check_slot("f4d1", 4'd8, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f4d2", 4'd7, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f4d3", 4'd6, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Test 4: digits 1 and 3 masked off, frame period unchanged
    en_mask = 4'b0101;
    check_slot("f5d0", 4'd9, 4'b1110, 1'b0, 1'b1, 1'b0);
    check_slot("f5d1", 4'd8, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_slot("f5d2", 4'd7, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f5d3", 4'd6, 4'b1111, 1'b0, 1'b0, 1'b0);
    en_mask = 4'b1111;

    // Test 6: request withdrawn before the boundary, then a proper load with dp on digit 2
    check_slot("f6d0", 4'd9, 4'b1110, 1'b0, 1'b1, 1'b0);
    a = 4'd5; b = 4'd5; c = 4'd5; d = 4'd5;
    load_req = 1'b1;
    tick(); tick(); tick();
    load_req = 1'b0;
    repeat (PRESCALE - 3) tick();
    check_slot("f6d2", 4'd7, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f6d3", 4'd6, 4'b0111, 1'b0, 1'b0, 1'b0);
    check_slot("f7d0", 4'd9, 4'b1110, 1'b0, 1'b1, 1'b0);
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    dp_in = 4'b0100;
    load_req = 1'b1;
    check_slot("f7d1", 4'd8, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f7d2", 4'd7, 4'b1011, 1'b0, 1'b0, 1'b0);
    check_slot("f7d3", 4'd6, 4'b0111, 1'b0, 1'b0, 1'b0);
    check_slot("f8d0", 4'd1, 4'b1110, 1'b0, 1'b1, 1'b1);
    load_req = 1'b0;
    check_slot("f8d1", 4'd2, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_slot("f8d2", 4'd3, 4'b1011, 1'b1, 1'b0, 1'b0);
    check_slot("f8d3", 4'd4, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Test 5: reset during the ON phase of digit 2 with a pending load
    check_slot("f9d0", 4'd1, 4'b1110, 1'b0, 1'b1, 1'b0);
    check_slot("f9d1", 4'd2, 4'b1101, 1'b0, 1'b0, 1'b0);
    a = 4'd7; b = 4'd7; c = 4'd7; d = 4'd7;
    load_req = 1'b1;
    repeat (4) tick();
    check_output("f9d2 pre-reset anode", anode, 4'b1011);
    reset = 1'b0;
    #1;
    check_output("mid reset anode", anode, 4'b1111);
    check_output("mid reset load_ack", {3'b000, load_ack}, 4'd0);
    check_output("mid reset nibble", nibble, 4'd0);
    check_output("mid reset dp", {3'b000, dp}, 4'd0);
    tick();
    tick();
    check_output("mid reset hold anode", anode, 4'b1111);
    load_req = 1'b0;
    reset = 1'b1;
    check_slot("r1d0", 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    check_slot("r1d1", 4'd0, 4'b1101, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
